bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter that consumes the 13-bit result of the upstream sequence-generator stage (o_val/o_done) and produces packed BCD digits plus a leading-zero blank mask.
- The downstream seven-segment display multiplexer uses these outputs.
- Uses iterative shift-add-3 (double dabble): one input bit per clock.
- Has a start/done/clear handshake identical in style to the upstream stage.

---
 rtl/bin2bcd_seq.sv | 159 +++++++++++++++
 tb/tb_bin2bcd_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// A start in IDLE latches the binary value, W clocks later the packed BCD
// result and its leading-zero blank mask are registered and DONE is entered.
// The result is held until the next conversion completes; a clear in DONE
// returns to IDLE without touching the held result.
//
// Ports:
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous reset, active-high
//   i_start  : start a conversion (sampled only in IDLE)
//   i_clear  : acknowledge result (sampled only in DONE)
//   i_bin    : unsigned binary input, latched on the accepted start edge
//   o_ready  : high while in IDLE
//   o_done   : high while in DONE
//   o_bcd    : packed BCD, digit k at [4k+3:4k], k=0 is the units digit
//   o_blank  : bit k set when digit k is a leading zero (bit 0 always 0)
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int W = 13,
  parameter int D = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_clear,
  input  logic [W-1:0]   i_bin,
  output logic           o_ready,
  output logic           o_done,
  output logic [4*D-1:0] o_bcd,
  output logic [D-1:0]   o_blank
);

  localparam int BW = 4 * D;
  localparam int CW = $clog2(W + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam longint unsigned BCD_RANGE = pow10(D);
  localparam longint unsigned BIN_MAX   = (64'd1 << W) - 64'd1;

  // D digits must be able to hold the largest W-bit value.
  if (BCD_RANGE <= BIN_MAX) begin : g_bad_params
    $error("bin2bcd_seq: D=%0d digits cannot represent W=%0d bits", D, W);
  end

  // Add-3 correction applied independently to every digit that is >= 5,
  // so that the following left shift carries correctly into the next digit.
  function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int k = 0; k < D; k++) begin
      if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Leading-zero mask: bit k set iff digit k and every higher digit are 0.
  // The units digit is never blanked so a zero value still shows "0".
  function automatic logic [D-1:0] blank_mask(input logic [BW-1:0] b);
    logic [D-1:0] m;
    logic         zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int k = D - 1; k >= 1; k--) begin
      zero_above = zero_above & (b[4*k +: 4] == 4'd0);
      m[k]       = zero_above;
    end
    return m;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [W-1:0]    bin_q;
  logic [BW-1:0]   bcd_q;
  logic [CW-1:0]   cnt_q;

  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_shift;
  logic [W-1:0]    bin_shift;
  logic            last_shift;

  // Correct-then-shift of the combined {bcd, bin} register.
  always_comb begin
    bcd_adj    = add3_digits(bcd_q);
    bcd_shift  = {bcd_adj[BW-2:0], bin_q[W-1]};
    bin_shift  = {bin_q[W-2:0], 1'b0};
    last_shift = (cnt_q == CW'(1));
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start)    state_d = S_CONV;
      S_CONV:  if (last_shift) state_d = S_DONE;
      S_DONE:  if (i_clear)    state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_ready = (state_q == S_IDLE);
    o_done  = (state_q == S_DONE);
  end

  // Working registers and registered result. o_bcd/o_blank are written only
  // on the final shift, so a partial result is never visible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      o_bcd   <= '0;
      o_blank <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            bin_q <= i_bin;
            bcd_q <= '0;
            cnt_q <= CW'(W);
          end
        end
        S_CONV: begin
          bcd_q <= bcd_shift;
          bin_q <= bin_shift;
          cnt_q <= cnt_q - CW'(1);
          if (last_shift) begin
            o_bcd   <= bcd_shift;
            o_blank <= blank_mask(bcd_shift);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  localparam int W = 13;
  localparam int D = 4;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_start = 1'b0;
  logic           i_clear = 1'b0;
  logic [W-1:0]   i_bin = '0;
  logic           o_ready;
  logic           o_done;
  logic [4*D-1:0] o_bcd;
  logic [D-1:0]   o_blank;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  bin2bcd_seq #(.W(W), .D(D)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .i_clear(i_clear),
    .i_bin  (i_bin),
    .o_ready(o_ready),
    .o_done (o_done),
    .o_bcd  (o_bcd),
    .o_blank(o_blank)
  );

  always #5 i_clk = ~i_clk;

  // Reference: decimal digits by division, blank mask from the digits.
  function automatic logic [4*D-1:0] ref_bcd(input int v);
    logic [4*D-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] ref_blank(input int v);
    logic [D-1:0] m;
    int p;
    m = '0;
    p = 10;
    for (int k = 1; k < D; k++) begin
      m[k] = (v < p);
      p = p * 10;
    end
    return m;
  endfunction

  // Transaction-level model: ready / busy-countdown / done, result on finish.
  bit             m_ready = 1'b1;
  bit             m_done  = 1'b0;
  int             m_left  = 0;
  int             m_val   = 0;
  logic [4*D-1:0] m_bcd   = '0;
  logic [D-1:0]   m_blank = '0;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_ready = 1'b1;
      m_done  = 1'b0;
      m_left  = 0;
      m_bcd   = '0;
      m_blank = '0;
    end else if (m_ready) begin
      if (i_start) begin
        m_ready = 1'b0;
        m_left  = W;
        m_val   = int'(i_bin);
      end
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done  = 1'b1;
        m_bcd   = ref_bcd(m_val);
        m_blank = ref_blank(m_val);
      end
    end else if (m_done && i_clear) begin
      m_done  = 1'b0;
      m_ready = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("cyc_ready", 32'(o_ready), 32'(m_ready));
      chk("cyc_done",  32'(o_done),  32'(m_done));
      chk("cyc_bcd",   32'(o_bcd),   32'(m_bcd));
      chk("cyc_blank", 32'(o_blank), 32'(m_blank));
    end
  end

  // Start a conversion and measure the cycles from start edge to o_done.
  task automatic run(input int val, input bit disturb, output int lat);
    @(posedge i_clk); #1;
    i_bin   = W'(val);
    i_start = 1'b1;
    @(posedge i_clk); #1;       // start edge
    i_start = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge i_clk); #1;
      if (disturb && cyc == 3) begin
        i_start = 1'b1;
        i_bin   = '0;
      end
      if (disturb && cyc == 4) begin
        i_start = 1'b0;
        i_bin   = '1;
      end
      if (o_done) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic clear_result();
    @(posedge i_clk); #1;
    i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    chk("clr_ready", 32'(o_ready), 32'd1);
    chk("clr_done",  32'(o_done),  32'd0);
  endtask

  int lat;

  initial begin
    // Pin the reference functions themselves.
    chk("ref_bcd_8191",  32'(ref_bcd(8191)),  32'h8191);
    chk("ref_bcd_32",    32'(ref_bcd(32)),    32'h0032);
    chk("ref_blank_999", 32'(ref_blank(999)), 32'b1000);
    chk("ref_blank_0",   32'(ref_blank(0)),   32'b1110);

    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_done",  32'(o_done),  32'd0);
    chk("rst_bcd",   32'(o_bcd),   32'd0);
    chk("rst_blank", 32'(o_blank), 32'd0);
    chk_en = 1'b1;

    run(0, 1'b0, lat);
    chk("lat_0",   32'(lat),     32'd13);
    chk("bcd_0",   32'(o_bcd),   32'h0000);
    chk("blank_0", 32'(o_blank), 32'b1110);

    clear_result();
    run(8191, 1'b0, lat);
    chk("lat_8191",   32'(lat),     32'd13);
    chk("bcd_8191",   32'(o_bcd),   32'h8191);
    chk("blank_8191", 32'(o_blank), 32'b0000);
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk); #1;
      chk("hold_done", 32'(o_done), 32'd1);
      chk("hold_bcd",  32'(o_bcd),  32'h8191);
    end
    clear_result();
    chk("clr_keeps_bcd", 32'(o_bcd), 32'h8191);

    run(5, 1'b0, lat);
    chk("bcd_5",   32'(o_bcd),   32'h0005);
    chk("blank_5", 32'(o_blank), 32'b1110);
    clear_result();

    run(32, 1'b0, lat);
    chk("bcd_32",   32'(o_bcd),   32'h0032);
    chk("blank_32", 32'(o_blank), 32'b1100);
    clear_result();

    run(1234, 1'b0, lat);
    chk("bcd_1234",   32'(o_bcd),   32'h1234);
    chk("blank_1234", 32'(o_blank), 32'b0000);
    clear_result();

    // Start pulse and input change while converting must not disturb it.
    run(4321, 1'b1, lat);
    chk("lat_disturb",  32'(lat),   32'd13);
    chk("bcd_disturb",  32'(o_bcd), 32'h4321);

    // Start and clear together in DONE: clear wins, no new conversion.
    @(posedge i_clk); #1;
    i_bin   = W'(77);
    i_start = 1'b1;
    i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_clear = 1'b0;
    chk("both_ready", 32'(o_ready), 32'd1);
    repeat (16) @(posedge i_clk);
    #1;
    chk("both_no_conv_ready", 32'(o_ready), 32'd1);
    chk("both_no_conv_bcd",   32'(o_bcd),   32'h4321);

    // Clear in IDLE has no effect.
    i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    chk("idle_clr_ready", 32'(o_ready), 32'd1);
    chk("idle_clr_done",  32'(o_done),  32'd0);

    // Reset in the middle of a conversion.
    @(posedge i_clk); #1;
    i_bin   = W'(999);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    chk("midrst_busy", 32'(o_ready), 32'd0);
    i_rst = 1'b1;
    #1;
    chk("midrst_bcd",   32'(o_bcd),   32'd0);
    chk("midrst_done",  32'(o_done),  32'd0);
    chk("midrst_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    run(999, 1'b0, lat);
    chk("lat_999",   32'(lat),     32'd13);
    chk("bcd_999",   32'(o_bcd),   32'h0999);
    chk("blank_999", 32'(o_blank), 32'b1000);
    clear_result();

    repeat (2) @(posedge i_clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
